// File: rtl/sha1_round_scheduler_if.sv
// Control bundle between the SHA-1 round scheduler, the message source and the hash datapath.
// The scheduler takes the master modport; the source/datapath side takes the slave modport.
interface sha1_round_scheduler_if #(
  parameter int CHUNK_W = 8
);
  logic               start;
  logic [CHUNK_W-1:0] num_chunks;
  logic               word_valid;
  logic               word_ready;
  logic               busy;
  logic               done;
  logic [6:0]         round;
  logic [1:0]         fk_sel;
  logic [3:0]         w_addr;
  logic               w_expand;
  logic               en_init;
  logic               en_round;
  logic               en_update_hash;
  logic [CHUNK_W-1:0] chunk_idx;

  modport master (
    input  start, num_chunks, word_valid,
    output word_ready, busy, done, round, fk_sel, w_addr, w_expand,
           en_init, en_round, en_update_hash, chunk_idx
  );

  modport slave (
    output start, num_chunks, word_valid,
    input  word_ready, busy, done, round, fk_sel, w_addr, w_expand,
           en_init, en_round, en_update_hash, chunk_idx
  );
endinterface

// File: rtl/sha1_round_scheduler.sv
// Sequences a SHA-1 job over N chunks: INIT, 16 loaded rounds, 64 expanded rounds, hash update.
// Emits round index, f/K group, W ring slot and the datapath enables.
module sha1_round_scheduler #(
  parameter int CHUNK_W = 8
) (
  input logic                    clk,
  input logic                    reset,
  sha1_round_scheduler_if.master bus
);
  typedef enum logic [2:0] {
    S_IDLE, S_INIT, S_LOAD, S_EXPAND, S_UPDATE, S_DONE
  } state_t;

  state_t             state_q;
  logic [6:0]         round_q;
  logic [CHUNK_W-1:0] chunk_idx_q;
  logic [CHUNK_W-1:0] count_q;
  logic               busy_q;
  logic               done_q;
  logic               en_init_q;
  logic               en_update_hash_q;
  logic [CHUNK_W:0]   chunk_idx_d;
  logic               in_sched;

  // One extra bit so the last-chunk test stays correct at the maximum chunk count.
  assign chunk_idx_d = {1'b0, chunk_idx_q} + {{CHUNK_W{1'b0}}, 1'b1};

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q          <= S_IDLE;
      round_q          <= 7'd0;
      chunk_idx_q      <= '0;
      count_q          <= '0;
      busy_q           <= 1'b0;
      done_q           <= 1'b0;
      en_init_q        <= 1'b0;
      en_update_hash_q <= 1'b0;
    end else begin
      done_q           <= 1'b0;
      en_init_q        <= 1'b0;
      en_update_hash_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            count_q     <= bus.num_chunks;
            chunk_idx_q <= '0;
            busy_q      <= 1'b1;
            if (bus.num_chunks == '0) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q   <= S_INIT;
              round_q   <= 7'd0;
              en_init_q <= 1'b1;
            end
          end
        end
        S_INIT: state_q <= S_LOAD;
        S_LOAD: begin
          if (bus.word_valid) begin
            round_q <= round_q + 7'd1;
            if (round_q == 7'd15) state_q <= S_EXPAND;
          end
        end
        S_EXPAND: begin
          // Round parks at 79 through UPDATE rather than running past the schedule.
          if (round_q == 7'd79) begin
            state_q          <= S_UPDATE;
            en_update_hash_q <= 1'b1;
          end else begin
            round_q <= round_q + 7'd1;
          end
        end
        S_UPDATE: begin
          chunk_idx_q <= chunk_idx_d[CHUNK_W-1:0];
          if (chunk_idx_d < {1'b0, count_q}) begin
            state_q   <= S_INIT;
            round_q   <= 7'd0;
            en_init_q <= 1'b1;
          end else begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign in_sched = (state_q == S_LOAD) || (state_q == S_EXPAND);

  always_comb begin
    bus.fk_sel = 2'd0;
    if (in_sched) begin
      if (round_q < 7'd20)      bus.fk_sel = 2'd0;
      else if (round_q < 7'd40) bus.fk_sel = 2'd1;
      else if (round_q < 7'd60) bus.fk_sel = 2'd2;
      else                      bus.fk_sel = 2'd3;
    end
  end

  assign bus.w_addr         = in_sched ? round_q[3:0] : 4'd0;
  assign bus.w_expand       = (state_q == S_EXPAND);
  assign bus.word_ready     = (state_q == S_LOAD);
  assign bus.en_round       = ((state_q == S_LOAD) && bus.word_valid) || (state_q == S_EXPAND);
  assign bus.round          = round_q;
  assign bus.busy           = busy_q;
  assign bus.done           = done_q;
  assign bus.en_init        = en_init_q;
  assign bus.en_update_hash = en_update_hash_q;
  assign bus.chunk_idx      = chunk_idx_q;
endmodule

// File: tb/tb_sha1_round_scheduler.sv
// Directed bench for sha1_round_scheduler: table of job vectors plus reset and held-start sequences.
module tb_sha1_round_scheduler;
  localparam int CW = 8;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  sha1_round_scheduler_if #(.CHUNK_W(CW)) bus ();
  sha1_round_scheduler #(.CHUNK_W(CW)) dut (.clk(clk), .reset(reset), .bus(bus));

  int checks = 0;
  int errors = 0;

  typedef struct {
    int n;          // chunks in the job
    int stall_cyc;  // first cycle with word_valid low
    int stall_len;  // number of stalled cycles
    int stall_rnd;  // round expected to hold during the stall
    int exp_done;   // cycle in which done pulses (start accepted at edge 0)
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_busy"}, 32'(bus.busy), 0);
    chk({tag, "_done"}, 32'(bus.done), 0);
    chk({tag, "_ready"}, 32'(bus.word_ready), 0);
    chk({tag, "_en_round"}, 32'(bus.en_round), 0);
    chk({tag, "_en_init"}, 32'(bus.en_init), 0);
    chk({tag, "_en_upd"}, 32'(bus.en_update_hash), 0);
    chk({tag, "_fk"}, 32'(bus.fk_sel), 0);
    chk({tag, "_waddr"}, 32'(bus.w_addr), 0);
    chk({tag, "_wexp"}, 32'(bus.w_expand), 0);
  endtask

  // Called at posedge+1 with the scheduler idle; start is accepted at the next edge (edge 0).
  task automatic run_job(input int n, input int sc, input int sl, input int sr,
                         input bit hold, input int exp_done, input string tag);
    int cyc, done_cyc, n_init, n_round, n_upd, rr;
    bus.start      = 1'b1;
    bus.num_chunks = n[CW-1:0];
    bus.word_valid = 1'b1;
    @(posedge clk); #1;
    if (!hold) bus.start = 1'b0;
    bus.num_chunks = ~n[CW-1:0];
    cyc = 1; done_cyc = -1; n_init = 0; n_round = 0; n_upd = 0; rr = 0;
    while (done_cyc < 0 && cyc <= 2000) begin
      bus.word_valid = !(sl > 0 && cyc >= sc && cyc < sc + sl);
      #1;
      if (bus.en_init) begin
        chk({tag, "_chunk_idx"}, 32'(bus.chunk_idx), 32'(n_init));
        chk({tag, "_init_ready"}, 32'(bus.word_ready), 0);
        chk({tag, "_init_en_round"}, 32'(bus.en_round), 0);
        n_init++;
        rr = 0;
      end
      if (bus.word_ready || bus.w_expand) begin
        chk({tag, "_round"}, 32'(bus.round), 32'(rr));
        chk({tag, "_w_addr"}, 32'(bus.w_addr), 32'(rr % 16));
        chk({tag, "_w_expand"}, 32'(bus.w_expand), 32'(rr >= 16));
        chk({tag, "_fk_sel"}, 32'(bus.fk_sel), 32'(rr / 20));
      end
      if (sl > 0 && cyc >= sc && cyc < sc + sl) begin
        chk({tag, "_stall_round"}, 32'(bus.round), 32'(sr));
        chk({tag, "_stall_ready"}, 32'(bus.word_ready), 1);
        chk({tag, "_stall_en_round"}, 32'(bus.en_round), 0);
      end
      if (bus.en_round) begin
        n_round++;
        rr++;
      end
      if (bus.en_update_hash) n_upd++;
      if (bus.done) begin
        done_cyc = cyc;
        chk({tag, "_busy_in_done"}, 32'(bus.busy), 1);
      end else begin
        @(posedge clk); #1;
        cyc++;
      end
    end
    chk({tag, "_done_cycle"}, 32'(done_cyc), 32'(exp_done));
    chk({tag, "_n_init"}, 32'(n_init), 32'(n));
    chk({tag, "_n_round"}, 32'(n_round), 32'(80 * n));
    chk({tag, "_n_update"}, 32'(n_upd), 32'(n));
    @(posedge clk); #1;
    bus.word_valid = 1'b1;
    #1;
    chk_quiet({tag, "_after"});
    $display("job %s: chunks=%0d done_cycle=%0d init=%0d rounds=%0d updates=%0d",
             tag, n, done_cyc, n_init, n_round, n_upd);
  endtask

  initial begin
    vecs[0] = '{n: 1, stall_cyc: 0,  stall_len: 0, stall_rnd: 0, exp_done: 83};
    vecs[1] = '{n: 3, stall_cyc: 0,  stall_len: 0, stall_rnd: 0, exp_done: 247};
    vecs[2] = '{n: 1, stall_cyc: 9,  stall_len: 5, stall_rnd: 7, exp_done: 88};
    vecs[3] = '{n: 0, stall_cyc: 0,  stall_len: 0, stall_rnd: 0, exp_done: 1};
    vecs[4] = '{n: 2, stall_cyc: 90, stall_len: 3, stall_rnd: 6, exp_done: 168};

    bus.start      = 1'b0;
    bus.num_chunks = '0;
    bus.word_valid = 1'b1;
    reset          = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk_quiet("reset");
    chk("reset_round", 32'(bus.round), 0);
    chk("reset_chunk_idx", 32'(bus.chunk_idx), 0);
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_quiet("idle");

    for (int i = 0; i < 5; i++) begin
      run_job(vecs[i].n, vecs[i].stall_cyc, vecs[i].stall_len, vecs[i].stall_rnd,
              1'b0, vecs[i].exp_done, $sformatf("vec%0d", i));
    end

    // Reset in the middle of EXPAND, then a fresh job.
    bus.start      = 1'b1;
    bus.num_chunks = 8'd1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int i = 0; i < 100 && !(bus.w_expand && bus.round == 7'd40); i++) begin
      @(posedge clk); #1;
    end
    chk("midreset_reach_t40", 32'(bus.round), 40);
    reset = 1'b1;
    @(posedge clk); #1;
    chk_quiet("midreset");
    chk("midreset_round", 32'(bus.round), 0);
    chk("midreset_chunk_idx", 32'(bus.chunk_idx), 0);
    $display("midreset: busy=%0d round=%0d", bus.busy, bus.round);
    reset = 1'b0;
    run_job(1, 0, 0, 0, 1'b0, 83, "post_reset");

    // start held high for the whole job: a second job begins only after IDLE.
    run_job(1, 0, 0, 0, 1'b1, 83, "held");
    @(posedge clk); #1;
    chk("held_restart_busy", 32'(bus.busy), 1);
    chk("held_restart_init", 32'(bus.en_init), 1);
    chk("held_restart_chunk_idx", 32'(bus.chunk_idx), 0);
    $display("held: restart busy=%0d en_init=%0d", bus.busy, bus.en_init);
    bus.start = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
